clken_gen_frac: RTL and testbench

- Parametrised fractional clock-enable generator; successor to the fixed 3-output PLL wrapper.
- Runs entirely on the PLL master clock, 42 MHz in this core.
- Produces NUM_CH independent strobes at rates refclk*NUM/DEN, plus matching half-rate toggle outputs.
- Adds run-time reprogramming, phase re-alignment and a lock flag, so slow system clocks (CPU 3.652173 MHz, video 7 MHz) become single-domain enables instead of extra PLL outputs.

---
 rtl/clken_pkg.sv | 20 ++
 rtl/clken_chan.sv | 51 +++++
 rtl/clken_gen_frac.sv | 92 +++++++++
 tb/tb_clken_gen_frac.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/clken_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
package clken_pkg;

  localparam int ACC_W_DEF = 16;  // default numerator/denominator/accumulator width
  localparam int ACC_W_MAX = 32;  // widest ACC_W the config bus can carry
  localparam int CH_IDX_W  = 3;   // channel index width (up to 8 channels)

  // One channel's rate, zero-extended to the widest supported width.
  typedef struct packed {
    logic [ACC_W_MAX-1:0] num;
    logic [ACC_W_MAX-1:0] den;
  } chan_cfg_t;

  // A rate is legal when it never asks for more than one strobe per cycle.
  function automatic logic cfg_valid(input logic [ACC_W_MAX-1:0] num,
                                     input logic [ACC_W_MAX-1:0] den);
    return (den != '0) && (num <= den);
  endfunction

endpackage

// File: rtl/clken_chan.sv
// One fractional-rate channel: phase accumulator, enable strobe and toggle.
module clken_chan #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] num,
  input  logic [ACC_W-1:0] den,
  input  logic             clear,
  output logic             ce,
  output logic             outclk
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ce_q, ce_d;
  logic             outclk_q, outclk_d;
  logic [ACC_W:0]   sum;

  // Next accumulator state; sum carries one extra bit so acc+num never wraps.
  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, num};
    acc_d    = sum[ACC_W-1:0];
    ce_d     = 1'b0;
    outclk_d = outclk_q;
    if (clear) begin
      acc_d    = '0;
      outclk_d = 1'b0;
    end else if (sum >= {1'b0, den}) begin
      acc_d    = ACC_W'(sum - {1'b0, den});
      ce_d     = 1'b1;
      outclk_d = ~outclk_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      ce_q     <= 1'b0;
      outclk_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      ce_q     <= ce_d;
      outclk_q <= outclk_d;
    end
  end

  assign ce     = ce_q;
  assign outclk = outclk_q;

endmodule

// File: rtl/clken_gen_frac.sv
// Fractional clock-enable generator: NUM_CH strobes at refclk*num/den with
// run-time reprogramming, global phase re-alignment and a lock flag.
module clken_gen_frac
  import clken_pkg::*;
#(
  parameter int                      NUM_CH      = 3,
  parameter int                      ACC_W       = ACC_W_DEF,
  parameter logic [NUM_CH*ACC_W-1:0] DEF_NUM     = {16'd1, 16'd1, 16'd2},
  parameter logic [NUM_CH*ACC_W-1:0] DEF_DEN     = {16'd1, 16'd6, 16'd23},
  parameter int                      LOCK_CYCLES = 64
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
  output logic                cfg_err,
  input  logic                resync,
  output logic [NUM_CH-1:0]   ce,
  output logic [NUM_CH-1:0]   outclk,
  output logic                locked
);

  localparam int LK_W = $clog2(LOCK_CYCLES + 1);

  logic [NUM_CH-1:0][ACC_W-1:0] num_q, num_d;
  logic [NUM_CH-1:0][ACC_W-1:0] den_q, den_d;
  logic [NUM_CH-1:0]            clr;
  logic [LK_W-1:0]              lock_cnt_q, lock_cnt_d;
  logic                         locked_q, locked_d;
  logic                         cfg_err_q, cfg_err_d;
  chan_cfg_t                    wr;
  logic                         wr_ok;

  // Validate the write, update the rate file, fan out clears, run the lock counter.
  always_comb begin
    wr.num = ACC_W_MAX'(cfg_num);
    wr.den = ACC_W_MAX'(cfg_den);
    wr_ok  = cfg_we && (int'(cfg_ch) < NUM_CH) && cfg_valid(wr.num, wr.den);
    num_d  = num_q;
    den_d  = den_q;
    clr    = {NUM_CH{resync}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_ok && (cfg_ch == CH_IDX_W'(i))) begin
        num_d[i] = cfg_num;
        den_d[i] = cfg_den;
        clr[i]   = 1'b1;
      end
    end
    cfg_err_d  = cfg_we && !wr_ok;
    lock_cnt_d = lock_cnt_q;
    if (wr_ok || resync)
      lock_cnt_d = '0;
    else if (lock_cnt_q != LK_W'(LOCK_CYCLES))
      lock_cnt_d = lock_cnt_q + 1'b1;
    locked_d = (lock_cnt_d == LK_W'(LOCK_CYCLES));
  end

  // Configuration and status registers; reset drops any pending write.
  always_ff @(posedge refclk) begin
    if (rst) begin
      num_q      <= DEF_NUM;
      den_q      <= DEF_DEN;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      num_q      <= num_d;
      den_q      <= den_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;
  assign locked  = locked_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clken_chan #(.ACC_W(ACC_W)) u_chan (
      .clk    (refclk),
      .rst    (rst),
      .num    (num_q[g]),
      .den    (den_q[g]),
      .clear  (clr[g]),
      .ce     (ce[g]),
      .outclk (outclk[g])
    );
  end

endmodule

// File: tb/tb_clken_gen_frac.sv
// Self-checking bench: ideal-rate model (strobe count = floor(n*num/den)
// since the last clear) compared every cycle, plus literal timing pins.
module tb_clken_gen_frac;

  localparam int NCH  = 3;
  localparam int LOCK = 64;

  logic        refclk = 1'b0;
  logic        rst, cfg_we, resync, cfg_err, locked;
  logic [2:0]  cfg_ch;
  logic [15:0] cfg_num, cfg_den;
  logic [NCH-1:0] ce, outclk;

  // narrow-accumulator instance, no reconfiguration
  logic       rst2;
  logic       we2 = 1'b0, rs2 = 1'b0;
  logic [2:0] ch2 = 3'd0;
  logic [7:0] num2 = 8'd0, den2 = 8'd0;
  logic       cfg_err2, locked2;
  logic [1:0] ce2, outclk2;

  always #5 refclk = ~refclk;

  clken_gen_frac dut (
    .refclk(refclk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_num(cfg_num), .cfg_den(cfg_den), .cfg_err(cfg_err),
    .resync(resync), .ce(ce), .outclk(outclk), .locked(locked)
  );

  clken_gen_frac #(
    .NUM_CH(2), .ACC_W(8), .DEF_NUM({8'd1, 8'd255}), .DEF_DEN({8'd255, 8'd255}),
    .LOCK_CYCLES(LOCK)
  ) dut2 (
    .refclk(refclk), .rst(rst2), .cfg_we(we2), .cfg_ch(ch2),
    .cfg_num(num2), .cfg_den(den2), .cfg_err(cfg_err2),
    .resync(rs2), .ce(ce2), .outclk(outclk2), .locked(locked2)
  );

  // model state
  int unsigned DNUM [NCH] = '{2, 1, 1};
  int unsigned DDEN [NCH] = '{23, 6, 1};
  longint      n    [NCH];
  longint      mnum [NCH];
  longint      mden [NCH];
  int          lk;
  bit          merr;
  longint      n2;

  int     errors = 0, checks = 0;
  longint cecnt [NCH];
  longint cnt2_0, cnt2_1, cyc2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit ce_exp(input longint k, input longint nu, input longint de);
    if (k == 0) return 1'b0;
    return (k * nu / de) != ((k - 1) * nu / de);
  endfunction

  function automatic bit oc_exp(input longint k, input longint nu, input longint de);
    return ((k * nu / de) % 2) == 1;
  endfunction

  task automatic idle();
    rst = 1'b0; cfg_we = 1'b0; resync = 1'b0;
    cfg_ch = '0; cfg_num = '0; cfg_den = '0;
  endtask

  // One clock: advance the model from the inputs seen at the edge, then compare.
  task automatic tick();
    logic [NCH-1:0] ece, eoc;
    logic [1:0]     ece2, eoc2;
    bit ok;
    @(posedge refclk);
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        n[i] = 0; mnum[i] = DNUM[i]; mden[i] = DDEN[i];
      end
      lk = 0; merr = 1'b0;
    end else begin
      ok   = cfg_we && (cfg_ch < NCH) && (cfg_den != 0) && (cfg_num <= cfg_den);
      merr = cfg_we && !ok;
      for (int i = 0; i < NCH; i++) begin
        if (resync || (ok && cfg_ch == i)) n[i] = 0;
        else n[i]++;
      end
      if (ok) begin
        mnum[cfg_ch] = cfg_num; mden[cfg_ch] = cfg_den;
      end
      if (ok || resync) lk = 0;
      else if (lk < LOCK) lk++;
    end
    if (rst2) n2 = 0;
    else begin n2++; cyc2++; end
    #1;
    for (int i = 0; i < NCH; i++) begin
      ece[i] = ce_exp(n[i], mnum[i], mden[i]);
      eoc[i] = oc_exp(n[i], mnum[i], mden[i]);
      cecnt[i] += longint'(ce[i]);
    end
    ece2 = {ce_exp(n2, 1, 255), ce_exp(n2, 255, 255)};
    eoc2 = {oc_exp(n2, 1, 255), oc_exp(n2, 255, 255)};
    if (!rst2) begin
      cnt2_0 += longint'(ce2[0]);
      cnt2_1 += longint'(ce2[1]);
    end
    check("outs", 64'({ce, outclk, locked, cfg_err}),
          64'({ece, eoc, (lk == LOCK), merr}));
    check("outs8", 64'({ce2, outclk2, locked2, cfg_err2}),
          64'({ece2, eoc2, (n2 >= LOCK), 1'b0}));
  endtask

  initial begin
    int first1, firstlk, cnt, r;
    logic [5:0] pat0, pat1;
    for (int i = 0; i < NCH; i++) begin
      n[i] = 0; mnum[i] = DNUM[i]; mden[i] = DDEN[i]; cecnt[i] = 0;
    end
    lk = 0; merr = 1'b0; n2 = 0; cnt2_0 = 0; cnt2_1 = 0; cyc2 = 0;

    // reset
    idle(); rst = 1'b1; rst2 = 1'b1;
    tick(); tick();
    check("rst_ce", 64'(ce), 64'(0));
    check("rst_outclk", 64'(outclk), 64'(0));
    check("rst_locked", 64'(locked), 64'(0));
    check("rst_err", 64'(cfg_err), 64'(0));

    // default rates over 2300 cycles
    idle(); rst2 = 1'b0;
    for (int i = 0; i < NCH; i++) cecnt[i] = 0;
    first1 = -1; firstlk = -1;
    for (int k = 1; k <= 2300; k++) begin
      tick();
      if (ce[1] && first1 < 0) first1 = k;
      if (locked && firstlk < 0) firstlk = k;
    end
    check("cnt_ch0", 64'(cecnt[0]), 64'(200));
    check("cnt_ch1", 64'(cecnt[1]), 64'(383));
    check("cnt_ch2", 64'(cecnt[2]), 64'(2300));
    check("first_ce_ch1", 64'(first1), 64'(6));
    check("first_locked", 64'(firstlk), 64'(64));

    // reprogram ch1 to 1/4
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_num = 16'd1; cfg_den = 16'd4;
    tick(); idle();
    check("wr_lock_drop", 64'(locked), 64'(0));
    first1 = -1; firstlk = -1; cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (ce[1]) cnt++;
      if (ce[1] && first1 < 0) first1 = k;
      if (locked && firstlk < 0) firstlk = k;
    end
    check("wr_first_ce", 64'(first1), 64'(4));
    check("wr_cnt_ce", 64'(cnt), 64'(25));
    check("wr_relock", 64'(firstlk), 64'(64));

    // invalid writes: den=0, num>den, channel out of range
    for (int t = 0; t < 3; t++) begin
      cfg_we = 1'b1;
      cfg_ch  = (t == 2) ? 3'd3 : 3'd0;
      cfg_num = (t == 1) ? 16'd5 : 16'd1;
      cfg_den = (t == 0) ? 16'd0 : ((t == 1) ? 16'd3 : 16'd2);
      tick(); idle();
      check("bad_err_hi", 64'(cfg_err), 64'(1));
      check("bad_locked", 64'(locked), 64'(1));
      tick();
      check("bad_err_lo", 64'(cfg_err), 64'(0));
    end

    // resync together with ch0 <- 1/2
    resync = 1'b1; cfg_we = 1'b1; cfg_ch = 3'd0; cfg_num = 16'd1; cfg_den = 16'd2;
    tick(); idle();
    check("rs_outclk", 64'(outclk), 64'(0));
    pat0 = '0; pat1 = '0;
    for (int k = 0; k < 6; k++) begin
      tick(); pat0[k] = ce[0]; pat1[k] = ce[1];
    end
    check("rs_ch0_pat", 64'(pat0), 64'(6'b101010));
    check("rs_ch1_pat", 64'(pat1), 64'(6'b001000));

    // reset mid-stream with a write pending
    rst = 1'b1; cfg_we = 1'b1; cfg_ch = 3'd2; cfg_num = 16'd1; cfg_den = 16'd3;
    tick(); idle();
    check("mid_rst_outs", 64'({ce, outclk, locked, cfg_err}), 64'(0));
    pat0 = '0; pat1 = '0;
    for (int k = 0; k < 6; k++) begin
      tick(); pat0[k] = ce[2]; pat1[k] = ce[1];
    end
    check("mid_rst_ch2", 64'(pat0), 64'(6'b111111));
    check("mid_rst_ch1", 64'(pat1), 64'(6'b100000));

    // randomized traffic
    for (int k = 0; k < 8000; k++) begin
      idle();
      r = int'($urandom_range(0, 999));
      if (r < 30) begin
        cfg_we = 1'b1;
        cfg_ch = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
        if ($urandom_range(0, 4) == 0) begin
          cfg_den = 16'($urandom_range(1, 65535));
          cfg_num = 16'($urandom_range(0, int'(cfg_den)));
        end else begin
          cfg_den = 16'($urandom_range(0, 40));
          cfg_num = 16'($urandom_range(0, int'(cfg_den) + 2));
        end
      end
      resync = ($urandom_range(0, 99) == 0);
      rst    = ($urandom_range(0, 999) < 3);
      tick();
    end
    idle();

    // narrow accumulator long-run counts
    check("acc8_full", 64'(cnt2_0), 64'(cyc2));
    check("acc8_1of255", 64'(cnt2_1), 64'(cyc2 / 255));
    check("acc8_locked", 64'(locked2), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
